spi_master: RTL

// - Host-side SPI master for the frequency-meter SPI slave: one command byte with spi_dc_o=0,

---
 rtl/spi_master.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
//
// Host-side SPI master for the frequency-meter slave. A transaction is one
// command byte sent with spi_dc_o=0, followed by 0..8 read bytes clocked
// with spi_dc_o=1. Bytes received on MISO are returned one at a time to the
// local requester. SPI mode 0 (SCLK idles low), MSB first, one transaction
// per CS_N assertion.
//
// Parameters
//   CLK_DIV  system cycles per SCLK half-period (>= 4, the slave resyncs SCLK)
//   CS_GAP   minimum system cycles CS_N stays high between transactions (>= 1)
//
// Ports
//   clk_i, rst_n_i     system clock, asynchronous active-low reset
//   cmd_vld_i/rdy_o    request handshake; accepted only while idle
//   cmd_byte_i         command byte (e.g. register address)
//   rd_len_i           number of read bytes, values above 8 clamp to 8
//   rd_byte_vld_o      1-cycle strobe, rd_byte_data_o holds a received byte
//   done_o             1-cycle strobe when CS_N is released
//   busy_o             high from accept until the CS gap has elapsed
//   spi_sclk_o/mosi_o/cs_n_o/dc_o, spi_miso_i   SPI pins (MISO is async)
//
// Optional build macro SPI_MASTER_PACK64_EN adds
//   rd_word_vld_o      1-cycle strobe with done_o when at least one byte read
//   rd_word_data_o     read bytes packed big-endian (byte 0 -> [63:56]),
//                      unread bytes zero, held until the next packed word
// ---------------------------------------------------------------------------
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cmd_vld_i,
  output logic        cmd_rdy_o,
  input  logic [7:0]  cmd_byte_i,
  input  logic [3:0]  rd_len_i,
  output logic        rd_byte_vld_o,
  output logic [7:0]  rd_byte_data_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        spi_sclk_o,
  output logic        spi_mosi_o,
  output logic        spi_cs_n_o,
  output logic        spi_dc_o,
  input  logic        spi_miso_i
`ifdef SPI_MASTER_PACK64_EN
  ,
  output logic        rd_word_vld_o,
  output logic [63:0] rd_word_data_o
`endif
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(CS_GAP) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CMD,
    S_DATA,
    S_HOLD,
    S_GAP
  } state_t;

  state_t             state_q;
  logic [DIV_W-1:0]   div_q;
  logic [GAP_W-1:0]   gap_q;
  logic [2:0]         bit_cnt_q;
  logic [3:0]         byte_cnt_q;
  logic [3:0]         len_q;
  logic [6:0]         cmd_sh_q;
  logic [6:0]         rx_sh_q;
  logic               miso_s1_q;
  logic               miso_s2_q;
  logic               sclk_q;
  logic               mosi_q;
  logic               cs_n_q;
  logic               dc_q;
  logic               cmd_rdy_q;
  logic               busy_q;
  logic               rd_byte_vld_q;
  logic [7:0]         rd_byte_data_q;
  logic               done_q;

  logic               half_end;
  logic               byte_done;
  logic               hold_end;
  logic [3:0]         rd_len_d;
  logic [7:0]         rx_byte_d;

  // Last system cycle of the current SCLK half-period.
  assign half_end  = (div_q == DIV_LAST);
  assign rd_len_d  = (rd_len_i > 4'd8) ? 4'd8 : rd_len_i;
  assign rx_byte_d = {rx_sh_q, miso_s2_q};

  // bit_cnt_q advances on every rising SCLK edge, so it reads 0 during the
  // high phase that carries the 8th bit of a byte.
  assign byte_done = (state_q == S_DATA) && half_end && sclk_q && (bit_cnt_q == 3'd0);
  assign hold_end  = (state_q == S_HOLD) && half_end;

  // MISO arrives from another clock domain.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= spi_miso_i;
      miso_s2_q <= miso_s1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= S_IDLE;
      div_q          <= '0;
      gap_q          <= '0;
      bit_cnt_q      <= 3'd0;
      byte_cnt_q     <= 4'd0;
      len_q          <= 4'd0;
      cmd_sh_q       <= 7'd0;
      rx_sh_q        <= 7'd0;
      sclk_q         <= 1'b0;
      mosi_q         <= 1'b0;
      cs_n_q         <= 1'b1;
      dc_q           <= 1'b0;
      cmd_rdy_q      <= 1'b1;
      busy_q         <= 1'b0;
      rd_byte_vld_q  <= 1'b0;
      rd_byte_data_q <= 8'd0;
      done_q         <= 1'b0;
    end else begin
      rd_byte_vld_q <= 1'b0;
      done_q        <= 1'b0;

      if (state_q inside {S_SETUP, S_CMD, S_DATA, S_HOLD}) begin
        div_q <= half_end ? '0 : div_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_vld_i) begin
            len_q      <= rd_len_d;
            byte_cnt_q <= rd_len_d;
            cmd_sh_q   <= cmd_byte_i[6:0];
            mosi_q     <= cmd_byte_i[7];
            cs_n_q     <= 1'b0;
            dc_q       <= 1'b0;
            div_q      <= '0;
            bit_cnt_q  <= 3'd0;
            cmd_rdy_q  <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_SETUP;
          end
        end

        // CS_N low with bit 7 on MOSI for one half-period before the first
        // rising edge.
        S_SETUP: begin
          if (half_end) begin
            sclk_q    <= 1'b1;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            state_q   <= S_CMD;
          end
        end

        S_CMD: begin
          if (half_end) begin
            if (sclk_q) begin
              sclk_q <= 1'b0;
              if (bit_cnt_q == 3'd0) begin
                // 8th falling edge: command done, switch to data phase now
                // so dc is stable before the first data rising edge.
                mosi_q <= 1'b0;
                dc_q   <= (len_q != 4'd0);
              end else begin
                mosi_q   <= cmd_sh_q[6];
                cmd_sh_q <= {cmd_sh_q[5:0], 1'b0};
              end
            end else if (bit_cnt_q == 3'd0) begin
              if (len_q == 4'd0) begin
                state_q <= S_HOLD;
              end else begin
                sclk_q    <= 1'b1;
                bit_cnt_q <= bit_cnt_q + 3'd1;
                state_q   <= S_DATA;
              end
            end else begin
              sclk_q    <= 1'b1;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end

        // MISO is taken at the end of every high phase, i.e. as late as
        // possible so the slave's own input synchronisers have settled.
        S_DATA: begin
          if (half_end) begin
            if (sclk_q) begin
              sclk_q  <= 1'b0;
              rx_sh_q <= rx_byte_d[6:0];
              if (byte_done) begin
                rd_byte_vld_q  <= 1'b1;
                rd_byte_data_q <= rx_byte_d;
                byte_cnt_q     <= byte_cnt_q - 4'd1;
              end
            end else if ((bit_cnt_q == 3'd0) && (byte_cnt_q == 4'd0)) begin
              state_q <= S_HOLD;
            end else begin
              sclk_q    <= 1'b1;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end

        S_HOLD: begin
          if (hold_end) begin
            cs_n_q  <= 1'b1;
            dc_q    <= 1'b0;
            done_q  <= 1'b1;
            gap_q   <= '0;
            state_q <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            busy_q    <= 1'b0;
            cmd_rdy_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SPI_MASTER_PACK64_EN
  logic [63:0] word_acc_q;
  logic [63:0] rd_word_data_q;
  logic        rd_word_vld_q;
  logic [2:0]  byte_idx_d;
  logic [5:0]  byte_sh_d;

  // Index of the byte currently completing, counted from the first one.
  assign byte_idx_d = 3'(len_q - byte_cnt_q);
  assign byte_sh_d  = {byte_idx_d, 3'b000};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_acc_q     <= 64'd0;
      rd_word_data_q <= 64'd0;
      rd_word_vld_q  <= 1'b0;
    end else begin
      rd_word_vld_q <= 1'b0;
      if ((state_q == S_IDLE) && cmd_vld_i) begin
        word_acc_q <= 64'd0;
      end else if (byte_done) begin
        word_acc_q <= word_acc_q | ({rx_byte_d, 56'd0} >> byte_sh_d);
      end
      if (hold_end && (len_q != 4'd0)) begin
        rd_word_vld_q  <= 1'b1;
        rd_word_data_q <= word_acc_q;
      end
    end
  end

  assign rd_word_vld_o  = rd_word_vld_q;
  assign rd_word_data_o = rd_word_data_q;
`endif

  assign cmd_rdy_o      = cmd_rdy_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign rd_byte_vld_o  = rd_byte_vld_q;
  assign rd_byte_data_o = rd_byte_data_q;
  assign spi_sclk_o     = sclk_q;
  assign spi_mosi_o     = mosi_q;
  assign spi_cs_n_o     = cs_n_q;
  assign spi_dc_o       = dc_q;

endmodule
